// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports, scoreboard and clear control.
interface regfile_mp_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                 we0;
  logic [AW-1:0]        waddr0;
  logic [WIDTH-1:0]     wdata0;
  logic                 we1;
  logic [AW-1:0]        waddr1;
  logic [WIDTH-1:0]     wdata1;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*WIDTH-1:0] rdata;
  logic                 sb_set;
  logic [AW-1:0]        sb_addr;
  logic [DEPTH-1:0]     pending;
  logic                 clear_req;
  logic                 clear_busy;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, sb_set, sb_addr, clear_req,
    input  rdata, pending, clear_busy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, sb_set, sb_addr, clear_req,
    output rdata, pending, clear_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NRD combinational reads,
// per-register pending bits and a one-register-per-cycle clear sweep.
module regfile_mp #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  logic             idle;
  logic             wr0, wr1, set_ok;
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All external requests are gated by idle, so the sweep drops them and bypass is off.
  always_comb begin
    idle           = (state_q == IDLE);
    bus.clear_busy = !idle;
    wr0    = idle && bus.we0    && !((ZERO_REG != 0) && (bus.waddr0  == '0));
    wr1    = idle && bus.we1    && !((ZERO_REG != 0) && (bus.waddr1  == '0));
    set_ok = idle && bus.sb_set && !((ZERO_REG != 0) && (bus.sb_addr == '0));
  end

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (!idle) begin
      regs_d[cnt_q] = '0;
      pend_d[cnt_q] = 1'b0;
    end else begin
      if (wr0) begin
        regs_d[bus.waddr0] = bus.wdata0;
        pend_d[bus.waddr0] = 1'b0;
      end
      if (wr1) begin
        regs_d[bus.waddr1] = bus.wdata1;
        pend_d[bus.waddr1] = 1'b0;
      end
      if (set_ok) pend_d[bus.sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    ra        = '0;
    rd        = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = bus.raddr[k*AW +: AW];
      rd = regs_q[ra];
      if ((BYPASS != 0) && wr0 && (bus.waddr0 == ra)) rd = bus.wdata0;
      if ((BYPASS != 0) && wr1 && (bus.waddr1 == ra)) rd = bus.wdata1;
      if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
      bus.rdata[k*WIDTH +: WIDTH] = rd;
    end
  end

  assign bus.pending = pend_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Checks three regfile_mp variants (bypass, no bypass, zero register) driven in lockstep
// against a behavioural array model.
module tb_regfile_mp;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int N  = 2;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          we0, we1, sb_set, clear_req;
  logic [AW-1:0] waddr0, waddr1, sb_addr;
  logic [W-1:0]  wdata0, wdata1;
  logic [N*AW-1:0] raddr;

  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NRD(N)) ifa ();
  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NRD(N)) ifb ();
  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NRD(N)) ifc ();

  assign ifa.we0 = we0;  assign ifa.waddr0 = waddr0;  assign ifa.wdata0 = wdata0;
  assign ifa.we1 = we1;  assign ifa.waddr1 = waddr1;  assign ifa.wdata1 = wdata1;
  assign ifa.raddr = raddr;  assign ifa.sb_set = sb_set;  assign ifa.sb_addr = sb_addr;
  assign ifa.clear_req = clear_req;
  assign ifb.we0 = we0;  assign ifb.waddr0 = waddr0;  assign ifb.wdata0 = wdata0;
  assign ifb.we1 = we1;  assign ifb.waddr1 = waddr1;  assign ifb.wdata1 = wdata1;
  assign ifb.raddr = raddr;  assign ifb.sb_set = sb_set;  assign ifb.sb_addr = sb_addr;
  assign ifb.clear_req = clear_req;
  assign ifc.we0 = we0;  assign ifc.waddr0 = waddr0;  assign ifc.wdata0 = wdata0;
  assign ifc.we1 = we1;  assign ifc.waddr1 = waddr1;  assign ifc.wdata1 = wdata1;
  assign ifc.raddr = raddr;  assign ifc.sb_set = sb_set;  assign ifc.sb_addr = sb_addr;
  assign ifc.clear_req = clear_req;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .BYPASS(1), .ZERO_REG(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .BYPASS(0), .ZERO_REG(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .BYPASS(1), .ZERO_REG(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic [N*W-1:0] rd_o [3];
  logic [D-1:0]   pd_o [3];
  logic           bz_o [3];
  assign rd_o[0] = ifa.rdata;  assign pd_o[0] = ifa.pending;  assign bz_o[0] = ifa.clear_busy;
  assign rd_o[1] = ifb.rdata;  assign pd_o[1] = ifb.pending;  assign bz_o[1] = ifb.clear_busy;
  assign rd_o[2] = ifc.rdata;  assign pd_o[2] = ifc.pending;  assign bz_o[2] = ifc.clear_busy;

  // Reference state: instance 1 has no bypass, instance 2 hardwires register 0.
  logic [W-1:0] mem  [3][D];
  bit           pend [3][D];
  bit           clearing;
  int           clr_pos;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(int i, int a);
    if (i == 2 && a == 0) return '0;
    if (!clearing && i != 1) begin
      if (we1 && int'(waddr1) == a) return wdata1;
      if (we0 && int'(waddr0) == a) return wdata0;
    end
    return mem[i][a];
  endfunction

  function automatic logic [D-1:0] exp_pend(int i);
    logic [D-1:0] v;
    for (int a = 0; a < D; a++) v[a] = pend[i][a];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < D; a++) begin
        mem[i][a]  = '0;
        pend[i][a] = 0;
      end
    clearing = 0;
    clr_pos  = 0;
  endtask

  task automatic model_edge();
    if (clearing) begin
      for (int i = 0; i < 3; i++) begin
        mem[i][clr_pos]  = '0;
        pend[i][clr_pos] = 0;
      end
      clr_pos++;
      if (clr_pos == D) begin
        clearing = 0;
        clr_pos  = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (we0 && !(i == 2 && waddr0 == 0)) begin
          mem[i][waddr0] = wdata0;  pend[i][waddr0] = 0;
        end
        if (we1 && !(i == 2 && waddr1 == 0)) begin
          mem[i][waddr1] = wdata1;  pend[i][waddr1] = 0;
        end
        if (sb_set && !(i == 2 && sb_addr == 0)) pend[i][sb_addr] = 1;
      end
      if (clear_req) begin
        clearing = 1;
        clr_pos  = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [N*W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < N; k++) e[k*W +: W] = exp_rd(i, int'(raddr[k*AW +: AW]));
      chk($sformatf("rdata%0d", i), 64'(rd_o[i]), 64'(e));
      chk($sformatf("pending%0d", i), 64'(pd_o[i]), 64'(exp_pend(i)));
      chk($sformatf("busy%0d", i), 64'(bz_o[i]), 64'(clearing));
    end
  endtask

  task automatic idle_in();
    we0 = 0; we1 = 0; sb_set = 0; clear_req = 0;
    waddr0 = '0; waddr1 = '0; sb_addr = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_busy", 64'(ifa.clear_busy), 64'd0);
    #1 rst_n = 1'b1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    idle_in();
    we0 = 1; waddr0 = AW'(a); wdata0 = d;
    cycle();
  endtask

  int nbusy;

  initial begin
    rst_n = 1'b0;
    idle_in();
    raddr = '0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    chk("reset_rdata", 64'(ifa.rdata), 64'd0);
    chk("reset_pending", 64'(ifa.pending), 64'd0);

    for (int a = 0; a < D; a++) wr(a, W'((a + 1) * 8'h11));
    idle_in();
    raddr = {2'd3, 2'd1};
    #1 chk("read_r3_r1", 64'(ifa.rdata), 64'h4422);
    cycle();

    idle_in();
    we0 = 1; we1 = 1; waddr0 = 2'd2; waddr1 = 2'd2; wdata0 = 8'hAA; wdata1 = 8'h55;
    raddr = {2'd2, 2'd2};
    #1 chk("coll_bypass", 64'(ifa.rdata), 64'h5555);
    chk("coll_nobypass", 64'(ifb.rdata), 64'h3333);
    cycle();
    idle_in();
    #1 chk("coll_stored", 64'(ifb.rdata), 64'h5555);
    cycle();

    idle_in(); sb_set = 1; sb_addr = 2'd1;
    cycle();
    chk("sb_set_r1", 64'(ifa.pending), 64'b0010);
    wr(1, 8'h21);
    chk("sb_clr_r1", 64'(ifa.pending), 64'b0000);
    idle_in(); sb_set = 1; sb_addr = 2'd3; we1 = 1; waddr1 = 2'd3; wdata1 = 8'h99;
    cycle();
    chk("sb_set_wins", 64'(ifa.pending[3]), 64'd1);

    for (int a = 0; a < D; a++) wr(a, 8'hFF);
    idle_in(); clear_req = 1;
    cycle();
    nbusy = 0;
    for (int c = 0; c < 8; c++) begin
      if (ifa.clear_busy) nbusy++;
      idle_in();
      if (c == 1) begin we0 = 1; waddr0 = 2'd2; wdata0 = 8'h77; end
      raddr = N*AW'($urandom);
      cycle();
    end
    chk("sweep_cycles", 64'(nbusy), 64'd4);
    chk("sweep_pending", 64'(ifa.pending), 64'd0);
    raddr = {2'd2, 2'd3};
    #1 chk("sweep_dropped_wr", 64'(ifa.rdata), 64'h0000);

    for (int a = 0; a < D; a++) wr(a, W'(8'hC0 + a));
    idle_in(); clear_req = 1;
    cycle();
    idle_in();
    cycle();
    cycle();
    do_reset();
    raddr = {2'd3, 2'd2};
    #1 chk("midsweep_rdata", 64'(ifa.rdata), 64'd0);
    idle_in(); clear_req = 1;
    cycle();
    nbusy = 0;
    for (int c = 0; c < 8; c++) begin
      if (ifa.clear_busy) nbusy++;
      idle_in();
      cycle();
    end
    chk("fresh_sweep_cycles", 64'(nbusy), 64'd4);

    idle_in(); we0 = 1; waddr0 = 2'd0; wdata0 = 8'h5A; sb_set = 1; sb_addr = 2'd0;
    raddr = {2'd0, 2'd0};
    #1 chk("zero_bypass", 64'(ifc.rdata), 64'd0);
    cycle();
    idle_in();
    #1 chk("zero_read", 64'(ifc.rdata), 64'd0);
    chk("zero_pending", 64'(ifc.pending[0]), 64'd0);
    chk("nonzero_pending", 64'(ifa.pending[0]), 64'd1);
    cycle();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      we0 = 1'($urandom);   waddr0 = AW'($urandom);  wdata0 = W'($urandom);
      we1 = 1'($urandom);   waddr1 = AW'($urandom);  wdata1 = W'($urandom);
      sb_set = 1'($urandom); sb_addr = AW'($urandom);
      clear_req = ($urandom_range(0, 24) == 0);
      raddr = N*AW'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the datapath, replacing the fixed 4x8 single-write file.
- Adds:
  - two write ports with fixed priority
  - a configurable number of combinational read ports with optional write-to-read bypass
  - optional hardwired-zero register 0
  - per-register pending (scoreboard) bits for the issue logic
  - a multi-cycle sequential clear engine
- Sits between decode/issue and the ALU writeback path.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 4, number of registers; must be a power of 2 and >= 2; AW = $clog2(DEPTH).
- NRD, 2, number of read ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored value only.
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and never becomes pending.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- waddr1  in  AW  write address, port 1.
- wdata1  in  WIDTH  write data, port 1.
- raddr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rdata  out  NRD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH].
- sb_set  in  1  mark register sb_addr pending (instruction issued).
- sb_addr  in  AW  scoreboard set address.
- pending  out  DEPTH  per-register pending bits.
- clear_req  in  1  start a full clear sweep.
- clear_busy  out  1  high while the sweep runs.

Behaviour:
- **Reset:** rst_n low asynchronously forces all registers to 0, pending to 0, clear_busy to 0, FSM to IDLE and the sweep counter to 0.
- **Writes:** registered on the rising edge.
  - Data is visible on rdata the cycle after the edge.
  - With BYPASS=1 it is also visible combinationally in the write cycle.
- **Write collision:** both ports write the same address in the same cycle -> port 1 data stored; port 0 dropped. Different addresses -> both stored.
- **Reads:** purely combinational, no latency.
  - BYPASS=1: read address matching an active write in the same cycle returns that wdata (port 1 over port 0).
  - ZERO_REG=1 and address 0 -> always 0, including under bypass.
- **Pending bits:**
  - Any accepted write to addr clears pending[addr] on the edge.
  - sb_set sets pending[sb_addr].
  - Set and clear to the same address in the same cycle -> set wins (new producer issued).
  - ZERO_REG=1: pending[0] stays 0.
- **FSM:**
  - IDLE: clear_req=1 -> CLEAR, counter=0, clear_busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to regs[counter], clears pending[counter], then increments the counter.
    - counter==DEPTH-1 -> IDLE and clear_busy=0 on the following edge.
    - Sweep takes exactly DEPTH cycles.
  - CLEAR: we0, we1, sb_set and clear_req are ignored (dropped, no state change).
  - Reads remain active during CLEAR: swept registers read 0, unswept registers read old values. Bypass is suppressed during CLEAR.
  - clear_req held high in IDLE after a sweep -> a new sweep starts immediately.
- **Reset mid-sweep:** the asynchronous reset aborts the sweep; the block is fully zeroed with FSM in IDLE.
- **Counter wrap:** the counter is AW bits wide; it never exceeds DEPTH-1.

Test Plan:
- Reset then write sweep: after reset, all rdata = 0 and pending = 0. Write 0x11,0x22,0x33,0x44 to r0..r3 via port 0 (ZERO_REG=0). Read raddr={r3,r1} -> rdata = {0x44,0x22}.
- Collision: we0 = we1 = 1, both addr 2, wdata0 = 0xAA, wdata1 = 0x55. Next cycle r2 = 0x55. Same-cycle read of r2 with BYPASS=1 -> 0x55; with BYPASS=0 -> old value.
- Scoreboard: sb_set on r1 -> pending = 4'b0010. Write r1 -> pending = 0. Same-cycle sb_set r3 plus write r3 -> pending[3] = 1.
- Clear sweep: preload r0..r3 = 0xFF, pulse clear_req. clear_busy is high for exactly 4 cycles. A we0 to r2 = 0x77 during the sweep is dropped. End state: all regs 0, pending 0.
- Reset mid-sweep: assert rst_n low at cycle 2 of the sweep -> immediately all regs 0, clear_busy 0; the next clear_req starts a fresh 4-cycle sweep.
- ZERO_REG=1: write r0 = 0x5A and sb_set r0 -> r0 reads 0, pending[0] = 0, including the same-cycle bypass read.
